// File: rtl/mux_input_arbiter_pkg.sv
// Shared constants for the round-robin feeder in front of the 2-to-1 memory mux.
// Channel encodings double as selector values and last_grant values.
package mux_input_arbiter_pkg;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    localparam int DEFAULT_WIDTH = 2;
    localparam int DEFAULT_DEPTH = 4;

    // Pretending channel 1 won last makes channel 0 the first winner after reset.
    localparam logic LAST_GRANT_RST = CH1;

endpackage

// File: rtl/mux_input_arbiter_fifo_sync_lib.sv
// Small synchronous FIFO with a combinational head word, full/empty flags and a
// sticky overflow flag for pushes dropped while full.
module fifo_sync_lib #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             overflow_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign overflow = overflow_reg;
    assign rdata    = mem[rd_ptr_reg];

    // A pop on the same edge frees the slot, so a push at full still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + (PTR_W+1)'(1);
            end else if (!do_push && do_pop) begin
                count_reg <= count_reg - (PTR_W+1)'(1);
            end
            if (push && !do_push) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

endmodule

// File: rtl/mux_input_arbiter.sv
// Two buffered producer channels, round-robin arbitrated one word per cycle onto
// the selector/data_in0/data_in1 pins of the downstream registered mux.
module mux_input_arbiter
    import mux_input_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             push1,
    input  logic [WIDTH-1:0] wdata1,
    input  logic             ready,
    output logic             full0,
    output logic             full1,
    output logic             empty0,
    output logic             empty1,
    output logic             overflow0,
    output logic             overflow1,
    output logic             selector,
    output logic [WIDTH-1:0] data_in0,
    output logic [WIDTH-1:0] data_in1,
    output logic             valid_out
);

    logic [1:0]       push_v;
    logic [1:0]       pop_v;
    logic [1:0]       full_v;
    logic [1:0]       empty_v;
    logic [1:0]       overflow_v;
    logic [WIDTH-1:0] wdata_v [2];
    logic [WIDTH-1:0] rdata_v [2];

    logic             grant;
    logic             grant_ch;

    logic             selector_reg;
    logic [WIDTH-1:0] data_in0_reg;
    logic [WIDTH-1:0] data_in1_reg;
    logic             valid_reg;
    logic             last_grant_reg;

    assign push_v     = {push1, push0};
    assign wdata_v[0] = wdata0;
    assign wdata_v[1] = wdata1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            fifo_sync_lib #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH),
                .PTR_W (PTR_W)
            ) u_fifo (
                .clk      (clk),
                .reset    (reset),
                .push     (push_v[gi]),
                .wdata    (wdata_v[gi]),
                .pop      (pop_v[gi]),
                .rdata    (rdata_v[gi]),
                .full     (full_v[gi]),
                .empty    (empty_v[gi]),
                .overflow (overflow_v[gi])
            );
        end
    endgenerate

    // Only non-empty channels are ever granted, so a pop never hits an empty FIFO.
    always_comb begin
        grant    = 1'b0;
        grant_ch = CH0;
        if (ready) begin
            if (!empty_v[0] && !empty_v[1]) begin
                grant    = 1'b1;
                grant_ch = ~last_grant_reg;
            end else if (!empty_v[0]) begin
                grant    = 1'b1;
                grant_ch = CH0;
            end else if (!empty_v[1]) begin
                grant    = 1'b1;
                grant_ch = CH1;
            end
        end
    end

    assign pop_v[0] = grant && (grant_ch == CH0);
    assign pop_v[1] = grant && (grant_ch == CH1);

    always_ff @(posedge clk) begin
        if (reset) begin
            selector_reg   <= CH0;
            data_in0_reg   <= '0;
            data_in1_reg   <= '0;
            valid_reg      <= 1'b0;
            last_grant_reg <= LAST_GRANT_RST;
        end else begin
            valid_reg <= grant;
            if (grant) begin
                selector_reg   <= grant_ch;
                last_grant_reg <= grant_ch;
                if (grant_ch == CH0) begin
                    data_in0_reg <= rdata_v[0];
                end else begin
                    data_in1_reg <= rdata_v[1];
                end
            end
        end
    end

    assign full0     = full_v[0];
    assign full1     = full_v[1];
    assign empty0    = empty_v[0];
    assign empty1    = empty_v[1];
    assign overflow0 = overflow_v[0];
    assign overflow1 = overflow_v[1];
    assign selector  = selector_reg;
    assign data_in0  = data_in0_reg;
    assign data_in1  = data_in1_reg;
    assign valid_out = valid_reg;

endmodule

// File: tb/tb_mux_input_arbiter.sv
// Self-checking bench: per-cycle vector table plus hand-written sequences whose
// expected grants are queued when stimulus is driven and popped on valid_out.
module tb_mux_input_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       push0 = 1'b0;
    logic [1:0] wdata0 = 2'b00;
    logic       push1 = 1'b0;
    logic [1:0] wdata1 = 2'b00;
    logic       ready = 1'b0;
    logic       full0, full1, empty0, empty1, overflow0, overflow1;
    logic       selector, valid_out;
    logic [1:0] data_in0, data_in1;

    mux_input_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .push0     (push0),
        .wdata0    (wdata0),
        .push1     (push1),
        .wdata1    (wdata1),
        .ready     (ready),
        .full0     (full0),
        .full1     (full1),
        .empty0    (empty0),
        .empty1    (empty1),
        .overflow0 (overflow0),
        .overflow1 (overflow1),
        .selector  (selector),
        .data_in0  (data_in0),
        .data_in1  (data_in1),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       p0;
        logic [1:0] w0;
        logic       p1;
        logic [1:0] w1;
        logic       rdy;
        logic       e_valid;
        logic       e_sel;
        logic [1:0] e_d0;
        logic [1:0] e_d1;
        logic       e_empty0;
        logic       e_empty1;
        logic       e_full0;
        logic       e_full1;
    } vec_t;

    typedef struct {
        logic       ch;
        logic [1:0] data;
    } exp_t;

    vec_t tbl [13];
    exp_t sb [$];
    int   n_vec = 0;
    int   n_err = 0;
    int   grants = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic p0, input logic [1:0] w0,
                         input logic p1, input logic [1:0] w1, input logic rdy);
        reset  = r;
        push0  = p0;
        wdata0 = w0;
        push1  = p1;
        wdata1 = w1;
        ready  = rdy;
    endtask

    task automatic tick(input bit sb_en);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_en && valid_out) begin
            grants++;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got sel=%0d data0=%0h data1=%0h, expected no grant",
                         selector, data_in0, data_in1);
            end else begin
                e = sb.pop_front();
                check("sb_sel", {7'd0, selector}, {7'd0, e.ch});
                check("sb_data", {6'd0, (e.ch ? data_in1 : data_in0)}, {6'd0, e.data});
                $display("grant ch%0d data=%0h", e.ch, e.ch ? data_in1 : data_in0);
            end
        end
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        tick(0);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
    endtask

    initial begin
        // rst p0 w0 p1 w1 rdy | valid sel d0 d1 empty0 empty1 full0 full1
        tbl[0]  = '{1, 1, 2'b11, 0, 2'b00, 0,  0, 0, 2'b00, 2'b00, 1, 1, 0, 0};
        tbl[1]  = '{1, 1, 2'b11, 0, 2'b00, 0,  0, 0, 2'b00, 2'b00, 1, 1, 0, 0};
        tbl[2]  = '{0, 1, 2'b10, 0, 2'b00, 1,  0, 0, 2'b00, 2'b00, 0, 1, 0, 0};
        tbl[3]  = '{0, 0, 2'b00, 0, 2'b00, 1,  1, 0, 2'b10, 2'b00, 1, 1, 0, 0};
        tbl[4]  = '{0, 0, 2'b00, 0, 2'b00, 1,  0, 0, 2'b10, 2'b00, 1, 1, 0, 0};
        tbl[5]  = '{1, 0, 2'b00, 0, 2'b00, 0,  0, 0, 2'b00, 2'b00, 1, 1, 0, 0};
        tbl[6]  = '{0, 1, 2'b01, 1, 2'b11, 0,  0, 0, 2'b00, 2'b00, 0, 0, 0, 0};
        tbl[7]  = '{0, 1, 2'b10, 1, 2'b00, 0,  0, 0, 2'b00, 2'b00, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 2'b00, 0, 2'b00, 1,  1, 0, 2'b01, 2'b00, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 2'b00, 0, 2'b00, 1,  1, 1, 2'b01, 2'b11, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 2'b00, 0, 2'b00, 1,  1, 0, 2'b10, 2'b11, 1, 0, 0, 0};
        tbl[11] = '{0, 0, 2'b00, 0, 2'b00, 1,  1, 1, 2'b10, 2'b00, 1, 1, 0, 0};
        tbl[12] = '{0, 0, 2'b00, 0, 2'b00, 1,  0, 1, 2'b10, 2'b00, 1, 1, 0, 0};

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rst, tbl[i].p0, tbl[i].w0, tbl[i].p1, tbl[i].w1, tbl[i].rdy);
            tick(0);
            check($sformatf("row%0d_out", i),
                  {2'd0, valid_out, selector, data_in0, data_in1},
                  {2'd0, tbl[i].e_valid, tbl[i].e_sel, tbl[i].e_d0, tbl[i].e_d1});
            check($sformatf("row%0d_flags", i),
                  {4'd0, empty0, empty1, full0, full1},
                  {4'd0, tbl[i].e_empty0, tbl[i].e_empty1, tbl[i].e_full0, tbl[i].e_full1});
            $display("row %0d: valid=%0d sel=%0d d0=%0h d1=%0h", i, valid_out, selector, data_in0, data_in1);
        end
        check("reset_overflow0", {7'd0, overflow0}, 8'd0);

        // Overflow on channel 1: fifth push is dropped, flag is sticky until reset.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 2'b00, 1'b1, 2'(i), 1'b0);
            sb.push_back('{1'b1, 2'(i)});
            tick(1);
        end
        check("full1_after4", {7'd0, full1}, 8'd1);
        check("ovf1_before", {7'd0, overflow1}, 8'd0);
        drive(1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
        tick(1);
        check("ovf1_set", {7'd0, overflow1}, 8'd1);
        grants = 0;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        repeat (6) tick(1);
        check("ovf_drain_count", 8'(grants), 8'd4);
        check("ovf_drain_sb", 8'(sb.size()), 8'd0);
        check("empty1_drained", {7'd0, empty1}, 8'd1);
        check("ovf1_sticky", {7'd0, overflow1}, 8'd1);
        do_reset();
        check("ovf1_cleared", {7'd0, overflow1}, 8'd0);

        // Push into a full channel 0 on the same edge as its pop.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 2'(i), 1'b0, 2'b00, 1'b0);
            sb.push_back('{1'b0, 2'(i)});
            tick(1);
        end
        check("full0_preload", {7'd0, full0}, 8'd1);
        grants = 0;
        drive(1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 1'b1);
        sb.push_back('{1'b0, 2'b11});
        tick(1);
        check("pp_full0", {7'd0, full0}, 8'd1);
        check("pp_ovf0", {7'd0, overflow0}, 8'd0);
        check("pp_valid", {7'd0, valid_out}, 8'd1);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        repeat (6) tick(1);
        check("pp_grant_count", 8'(grants), 8'd5);
        check("pp_sb", 8'(sb.size()), 8'd0);
        check("pp_empty0", {7'd0, empty0}, 8'd1);

        // Backpressure with both channels loaded, then reset with three words queued.
        do_reset();
        drive(1'b0, 1'b1, 2'b01, 1'b1, 2'b10, 1'b0);
        tick(1);
        drive(1'b0, 1'b1, 2'b10, 1'b1, 2'b01, 1'b0);
        tick(1);
        drive(1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0);
        tick(1);
        sb.push_back('{1'b0, 2'b01});
        sb.push_back('{1'b1, 2'b10});
        drive(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        tick(1);
        tick(1);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check($sformatf("bp_hold%0d", i),
                  {2'd0, valid_out, selector, data_in0, data_in1},
                  {2'd0, 1'b0, 1'b1, 2'b01, 2'b10});
        end
        check("bp_sb", 8'(sb.size()), 8'd0);
        check("bp_not_empty", {6'd0, empty0, empty1}, 8'd0);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        tick(0);
        check("midrst_out", {2'd0, valid_out, selector, data_in0, data_in1}, 8'd0);
        check("midrst_empty", {6'd0, empty0, empty1}, 8'd3);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(0);
            check($sformatf("postrst_idle%0d", i), {7'd0, valid_out}, 8'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
